// File: rtl/total_supervisor.sv
// ---------------------------------------------------------------------------
// total_supervisor
//   Safety supervisor for the TOTAL hardware top. Watches NUM_ZONES thermal
//   sensors and one QRNG entropy stream, and drives Peltier cooling, system
//   halt and the security alarm through a latched four-state supervisor FSM.
//
//   Optional build macro: TOTAL_SUP_EVENT_CNT_EN
//     When defined, adds saturating 16-bit counters of HALT and ALARM entries
//     (halt_events, ent_events). These are not cleared by alarm_clr.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   temp_zones     in   packed zone temps, zone i at [i*TEMP_W +: TEMP_W]
//   entropy_data   in   raw QRNG sample
//   entropy_valid  in   entropy_data qualifier
//   alarm_clr      in   software clear (single-cycle pulse)
//   p_cooling_act  out  Peltier enable
//   system_halt    out  full stop
//   security_alarm out  alarm flag to software
//   sup_state      out  0 NORMAL, 1 ALARM, 2 HALT, 3 RECOVER
//   hot_zone       out  index of hottest zone (lowest index wins ties)
//   halt_events    out  HALT entry count   (TOTAL_SUP_EVENT_CNT_EN only)
//   ent_events     out  ALARM entry count  (TOTAL_SUP_EVENT_CNT_EN only)
// ---------------------------------------------------------------------------
module total_supervisor #(
  parameter int                NUM_ZONES    = 4,
  parameter int                TEMP_W       = 8,
  parameter int                ENT_W        = 64,
  parameter logic [TEMP_W-1:0] WARN_TH      = 8'd70,
  parameter logic [TEMP_W-1:0] CRIT_TH      = 8'd95,
  parameter logic [TEMP_W-1:0] HYST         = 8'd5,
  parameter int                DEBOUNCE_CYC = 4,
  parameter int                STUCK_LIMIT  = 3,
  parameter int                RECOVER_CYC  = 16,
  localparam int               ZW           = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_ZONES*TEMP_W-1:0] temp_zones,
  input  logic [ENT_W-1:0]            entropy_data,
  input  logic                        entropy_valid,
  input  logic                        alarm_clr,
  output logic                        p_cooling_act,
  output logic                        system_halt,
  output logic                        security_alarm,
  output logic [1:0]                  sup_state,
  output logic [ZW-1:0]               hot_zone
`ifdef TOTAL_SUP_EVENT_CNT_EN
  ,
  output logic [15:0]                 halt_events,
  output logic [15:0]                 ent_events
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(STUCK_LIMIT + 1);
  localparam int TW = $clog2(RECOVER_CYC + 1);

  localparam logic [CW-1:0]     CRIT_MAX    = CW'(DEBOUNCE_CYC);
  localparam logic [RW-1:0]     REP_MAX     = RW'(STUCK_LIMIT);
  localparam logic [TW-1:0]     REC_LAST    = TW'(RECOVER_CYC - 1);
  // Cooling release threshold, floored at zero when HYST exceeds WARN_TH.
  localparam logic [TEMP_W-1:0] COOL_OFF_TH = (WARN_TH > HYST) ? (WARN_TH - HYST) : '0;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ALARM   = 2'd1,
    ST_HALT    = 2'd2,
    ST_RECOVER = 2'd3
  } sup_state_e;

  function automatic int sat_inc(input int val, input int limit);
    return (val < limit) ? val + 1 : limit;
  endfunction

  // ---- stage 1: hottest-zone reduction -----------------------------------
  logic [TEMP_W-1:0] max_c;
  logic [ZW-1:0]     idx_c;
  logic [TEMP_W-1:0] max_p1;
  logic [ZW-1:0]     hot_p1;

  always_comb begin
    max_c = temp_zones[TEMP_W-1:0];
    idx_c = '0;
    // Strict compare keeps the lowest index on ties.
    for (int i = 1; i < NUM_ZONES; i++) begin
      if (temp_zones[i*TEMP_W +: TEMP_W] > max_c) begin
        max_c = temp_zones[i*TEMP_W +: TEMP_W];
        idx_c = ZW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_p1 <= '0;
      hot_p1 <= '0;
    end else begin
      max_p1 <= max_c;
      hot_p1 <= idx_c;
    end
  end

  // ---- stage 2: cooling hysteresis and critical debounce -----------------
  logic          cool_on_p2;
  logic [CW-1:0] crit_cnt_p2;
  logic          crit_hit;
  logic          cool_below;

  assign crit_hit   = (crit_cnt_p2 == CRIT_MAX);
  assign cool_below = (max_p1 < COOL_OFF_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool_on_p2  <= 1'b0;
      crit_cnt_p2 <= '0;
    end else begin
      if (max_p1 >= WARN_TH) begin
        cool_on_p2 <= 1'b1;
      end else if (cool_below) begin
        cool_on_p2 <= 1'b0;
      end
      if (max_p1 >= CRIT_TH) begin
        crit_cnt_p2 <= CW'(sat_inc(int'(crit_cnt_p2), DEBOUNCE_CYC));
      end else begin
        crit_cnt_p2 <= '0;
      end
    end
  end

  // ---- supervisor FSM ------------------------------------------------------
  sup_state_e    state;
  sup_state_e    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          clr_take;   // a clear accepted this cycle; also wipes entropy state
  logic          ent_fault;

  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    clr_take  = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (crit_hit) begin
          state_nxt = ST_HALT;
        end else if (ent_fault) begin
          state_nxt = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (crit_hit) begin
          state_nxt = ST_HALT;
        end else if (alarm_clr) begin
          state_nxt = ST_NORMAL;
          clr_take  = 1'b1;
        end
      end
      ST_HALT: begin
        // A clear while still hot is dropped, not remembered.
        if (!crit_hit && alarm_clr && cool_below) begin
          state_nxt = ST_RECOVER;
          clr_take  = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (crit_hit) begin
          state_nxt = ST_HALT;
        end else if (ent_fault) begin
          state_nxt = ST_ALARM;
        end else if (timer == REC_LAST) begin
          state_nxt = ST_NORMAL;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_NORMAL;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // ---- entropy repetition detector -----------------------------------------
  logic [ENT_W-1:0] prev_ent;
  logic [ENT_W-1:0] prev_ent_nxt;
  logic             prev_vld;
  logic             prev_vld_nxt;
  logic [RW-1:0]    rep_cnt;
  logic [RW-1:0]    rep_cnt_nxt;
  logic             ent_fault_nxt;

  always_comb begin
    prev_ent_nxt  = prev_ent;
    prev_vld_nxt  = prev_vld;
    rep_cnt_nxt   = rep_cnt;
    ent_fault_nxt = ent_fault;
    if (clr_take) begin
      // Clear beats any sample arriving in the same cycle.
      prev_vld_nxt  = 1'b0;
      rep_cnt_nxt   = '0;
      ent_fault_nxt = 1'b0;
    end else if (entropy_valid) begin
      prev_ent_nxt = entropy_data;
      prev_vld_nxt = 1'b1;
      if (prev_vld) begin
        if (entropy_data == prev_ent) begin
          rep_cnt_nxt = RW'(sat_inc(int'(rep_cnt), STUCK_LIMIT));
        end else begin
          rep_cnt_nxt = '0;
        end
      end
      if (rep_cnt_nxt == REP_MAX) begin
        ent_fault_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ent  <= '0;
      prev_vld  <= 1'b0;
      rep_cnt   <= '0;
      ent_fault <= 1'b0;
    end else begin
      prev_ent  <= prev_ent_nxt;
      prev_vld  <= prev_vld_nxt;
      rep_cnt   <= rep_cnt_nxt;
      ent_fault <= ent_fault_nxt;
    end
  end

`ifdef TOTAL_SUP_EVENT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_events <= '0;
      ent_events  <= '0;
    end else begin
      if ((state != ST_HALT) && (state_nxt == ST_HALT)) begin
        halt_events <= 16'(sat_inc(int'(halt_events), 65535));
      end
      if ((state != ST_ALARM) && (state_nxt == ST_ALARM)) begin
        ent_events <= 16'(sat_inc(int'(ent_events), 65535));
      end
    end
  end
`endif

  // ---- outputs decoded from registered state -------------------------------
  assign system_halt    = (state == ST_HALT);
  assign security_alarm = (state == ST_ALARM) || (state == ST_HALT);
  assign p_cooling_act  = cool_on_p2 || (state == ST_HALT) || (state == ST_RECOVER);
  assign sup_state      = state;
  assign hot_zone       = hot_p1;

endmodule

// File: tb/tb_total_supervisor.sv
module tb_total_supervisor;

  localparam int NZ    = 4;
  localparam int WARN  = 70;
  localparam int OFF   = 65;
  localparam int CRIT  = 95;
  localparam int DEB   = 4;
  localparam int STUCK = 3;
  localparam int REC   = 16;

  logic         clk;
  logic         rst_n;
  logic [7:0]   z [NZ];
  logic [31:0]  temp_zones;
  logic [63:0]  entropy_data;
  logic         entropy_valid;
  logic         alarm_clr;
  logic         p_cooling_act;
  logic         system_halt;
  logic         security_alarm;
  logic [1:0]   sup_state;
  logic [1:0]   hot_zone;
`ifdef TOTAL_SUP_EVENT_CNT_EN
  logic [15:0]  halt_events;
  logic [15:0]  ent_events;
`endif

  assign temp_zones = {z[3], z[2], z[1], z[0]};

  total_supervisor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .temp_zones     (temp_zones),
    .entropy_data   (entropy_data),
    .entropy_valid  (entropy_valid),
    .alarm_clr      (alarm_clr),
    .p_cooling_act  (p_cooling_act),
    .system_halt    (system_halt),
    .security_alarm (security_alarm),
    .sup_state      (sup_state),
    .hot_zone       (hot_zone)
`ifdef TOTAL_SUP_EVENT_CNT_EN
    ,
    .halt_events    (halt_events),
    .ent_events     (ent_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---- reference model: spec rules over history, not counters ----------
  int          m_state;      // 0 NORMAL, 1 ALARM, 2 HALT, 3 RECOVER
  int          m_max;
  int          m_hot;
  bit          m_cool;
  int          hist[$];      // last DEB registered maxima
  int          cyc;
  int          m_rec_start;
  bit          m_have_prev;
  logic [63:0] m_prev;
  int          m_run;        // length of the current run of identical samples
  bit          m_fault;
  int          m_halt_ev;
  int          m_ent_ev;

  task automatic model_reset();
    m_state = 0; m_max = 0; m_hot = 0; m_cool = 0;
    hist.delete();
    cyc = 0; m_rec_start = 0;
    m_have_prev = 0; m_prev = '0; m_run = 0; m_fault = 0;
    m_halt_ev = 0; m_ent_ev = 0;
  endtask

  task automatic model_edge();
    bit hit;
    bit take;
    int nst;
    hit = (hist.size() >= DEB);
    foreach (hist[i]) if (hist[i] < CRIT) hit = 0;
    take = 0;
    nst  = m_state;
    case (m_state)
      0: if (hit) nst = 2; else if (m_fault) nst = 1;
      1: if (hit) nst = 2; else if (alarm_clr) begin nst = 0; take = 1; end
      2: if (!hit && alarm_clr && (m_max < OFF)) begin nst = 3; take = 1; end
      default: if (hit) nst = 2; else if (m_fault) nst = 1;
               else if (cyc - m_rec_start == REC) nst = 0;
    endcase
    if (nst == 3 && m_state != 3) m_rec_start = cyc;
    if (nst == 2 && m_state != 2 && m_halt_ev < 65535) m_halt_ev++;
    if (nst == 1 && m_state != 1 && m_ent_ev < 65535) m_ent_ev++;

    if (take) begin
      m_have_prev = 0; m_run = 0; m_fault = 0;
    end else if (entropy_valid) begin
      if (m_have_prev && entropy_data == m_prev) m_run++;
      else m_run = 1;
      m_prev = entropy_data;
      m_have_prev = 1;
      if (m_run > STUCK) m_fault = 1;
    end

    if (m_max >= WARN) m_cool = 1;
    else if (m_max < OFF) m_cool = 0;

    hist.push_back(m_max);
    if (hist.size() > DEB) void'(hist.pop_front());

    m_max = int'(z[0]); m_hot = 0;
    for (int k = 1; k < NZ; k++)
      if (int'(z[k]) > m_max) begin m_max = int'(z[k]); m_hot = k; end

    m_state = nst;
    cyc++;
  endtask

  task automatic check_outputs();
    chk("state", int'(sup_state), m_state);
    chk("halt", int'(system_halt), int'(m_state == 2));
    chk("alarm", int'(security_alarm), int'(m_state == 1 || m_state == 2));
    chk("cool", int'(p_cooling_act), int'(m_cool || m_state == 2 || m_state == 3));
    chk("hot_zone", int'(hot_zone), m_hot);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_zones(input int a, input int b, input int c, input int d);
    z[0] = 8'(a); z[1] = 8'(b); z[2] = 8'(c); z[3] = 8'(d);
  endtask

  task automatic clear_pulse();
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
  endtask

  // Cool down from HALT, clear into RECOVER, then run out the recovery timer.
  task automatic halt_to_normal();
    set_zones(40, 64, 60, 50);
    repeat (3) tick();
    clear_pulse();
    chk("enter_recover", int'(sup_state), 3);
    repeat (REC - 1) tick();
    chk("recover_hold", int'(sup_state), 3);
    tick();
    chk("recover_done", int'(sup_state), 0);
  endtask

  logic [63:0] ent_val;

  initial begin
    rst_n = 1'b1;
    set_zones(0, 0, 0, 0);
    entropy_data  = '0;
    entropy_valid = 1'b0;
    alarm_clr     = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(sup_state), 0);
    chk("rst_halt", int'(system_halt), 0);
    chk("rst_alarm", int'(security_alarm), 0);
    chk("rst_cool", int'(p_cooling_act), 0);
    chk("rst_hot", int'(hot_zone), 0);
    rst_n = 1'b1;

    // Cooling with hysteresis
    set_zones(40, 72, 60, 50);
    repeat (2) tick();
    chk("cool_on", int'(p_cooling_act), 1);
    chk("hot_idx", int'(hot_zone), 1);
    set_zones(40, 66, 60, 50);
    repeat (3) tick();
    chk("cool_hyst_hold", int'(p_cooling_act), 1);
    set_zones(40, 64, 60, 50);
    repeat (2) tick();
    chk("cool_off", int'(p_cooling_act), 0);

    // Critical debounce latency: halt after edge t+DEB+1
    set_zones(40, 64, 96, 50);
    for (int i = 0; i < DEB + 1; i++) begin
      tick();
      chk("halt_early", int'(system_halt), 0);
    end
    tick();
    chk("halt_latency", int'(system_halt), 1);
    chk("halt_alarm", int'(security_alarm), 1);

    // Clear while hot is ignored
    clear_pulse();
    tick();
    chk("hot_clear_ignored", int'(sup_state), 2);
    halt_to_normal();

    // Debounce broken by one cool sample
    set_zones(40, 64, 96, 50);
    repeat (3) tick();
    set_zones(40, 64, 80, 50);
    tick();
    set_zones(40, 64, 96, 50);
    for (int i = 0; i < DEB + 1; i++) begin
      tick();
      chk("rebounce_no_halt", int'(system_halt), 0);
    end
    tick();
    chk("rebounce_halt", int'(system_halt), 1);
    halt_to_normal();

    // Stuck entropy
    entropy_data  = 64'hDEAD_BEEF_0000_0001;
    entropy_valid = 1'b1;
    repeat (STUCK + 1) tick();
    entropy_valid = 1'b0;
    tick();
    chk("stuck_alarm_state", int'(sup_state), 1);
    chk("stuck_alarm", int'(security_alarm), 1);
    clear_pulse();
    chk("alarm_cleared", int'(sup_state), 0);
    entropy_valid = 1'b1;
    tick();
    entropy_valid = 1'b0;
    repeat (3) tick();
    chk("no_refault", int'(sup_state), 0);

    // Crit during RECOVER returns to HALT, then reset mid-HALT
    set_zones(40, 64, 96, 50);
    repeat (DEB + 2) tick();
    set_zones(40, 64, 60, 50);
    repeat (3) tick();
    clear_pulse();
    chk("recover_again", int'(sup_state), 3);
    set_zones(100, 64, 60, 50);
    repeat (DEB + 2) tick();
    chk("recover_to_halt", int'(sup_state), 2);
    chk("recover_hot_idx", int'(hot_zone), 0);
`ifdef TOTAL_SUP_EVENT_CNT_EN
    chk("halt_events", int'(halt_events), m_halt_ev);
    chk("ent_events", int'(ent_events), m_ent_ev);
    clear_pulse();
    chk("halt_events_kept", int'(halt_events), m_halt_ev);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(sup_state), 0);
    chk("async_rst_halt", int'(system_halt), 0);
    chk("async_rst_alarm", int'(security_alarm), 0);
    chk("async_rst_cool", int'(p_cooling_act), 0);
    chk("async_rst_hot", int'(hot_zone), 0);
    model_reset();
    tick();
    set_zones(40, 50, 60, 30);
    rst_n = 1'b1;

    // Randomized phase against the model
    ent_val = 64'h0123_4567_89AB_CDEF;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 3) == 0)
          for (int k = 0; k < NZ; k++)
            z[k] = 8'((s % 2 == 0) ? $urandom_range(80, 100) : $urandom_range(30, 66));
        entropy_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) ent_val = ent_val ^ 64'h1;
        entropy_data = ent_val;
        alarm_clr    = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    alarm_clr     = 1'b0;
    entropy_valid = 1'b0;
    tick();
`ifdef TOTAL_SUP_EVENT_CNT_EN
    chk("rand_halt_events", int'(halt_events), m_halt_ev);
    chk("rand_ent_events", int'(ent_events), m_ent_ev);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
